// File: rtl/tub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tub_pkg
// Brief    : Shared constants and types for the eight-digit seven-segment
//            scan driver. Segment codes are {a,b,c,d,e,f,g,dp}, active-high,
//            and every code has dp = 0.
// Revision : 1.0  initial release
// ============================================================================
package tub_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int NUM_SLOTS  = 4;

   // Bit position of each segment inside an 8-bit segment code
   localparam int SEG_BIT_A  = 7;
   localparam int SEG_BIT_B  = 6;
   localparam int SEG_BIT_C  = 5;
   localparam int SEG_BIT_D  = 4;
   localparam int SEG_BIT_E  = 3;
   localparam int SEG_BIT_F  = 2;
   localparam int SEG_BIT_G  = 1;
   localparam int SEG_BIT_DP = 0;

   localparam logic [7:0] SEG_0     = 8'hFC;
   localparam logic [7:0] SEG_1     = 8'h60;
   localparam logic [7:0] SEG_2     = 8'hDA;
   localparam logic [7:0] SEG_3     = 8'hF2;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'hB6;
   localparam logic [7:0] SEG_6     = 8'hBE;
   localparam logic [7:0] SEG_7     = 8'hE0;
   localparam logic [7:0] SEG_8     = 8'hFE;
   localparam logic [7:0] SEG_9     = 8'hF6;
   localparam logic [7:0] SEG_A     = 8'hEE;
   localparam logic [7:0] SEG_B     = 8'h3E;
   localparam logic [7:0] SEG_C     = 8'h9C;
   localparam logic [7:0] SEG_D     = 8'h7A;
   localparam logic [7:0] SEG_E     = 8'h9E;
   localparam logic [7:0] SEG_F     = 8'h8E;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   // One complete display frame: hex digits plus the three per-digit masks
   typedef struct packed {
      logic [NUM_DIGITS*4-1:0] digits;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   blank;
      logic [NUM_DIGITS-1:0]   blink;
   } frame_t;

endpackage
`default_nettype wire

// File: rtl/seg7_encoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_encoder
// Brief    : Combinational hex nibble to seven-segment code {a..g}; the
//            decimal point is appended by the parent.
// Revision : 1.0  initial release
// ============================================================================
module seg7_encoder
   import tub_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segs
);

   // Table lookup of the a..g segments for each hex value
   always_comb begin
      segs = SEG_BLANK[7:1];
      case (nibble)
         4'h0: segs = SEG_0[7:1];
         4'h1: segs = SEG_1[7:1];
         4'h2: segs = SEG_2[7:1];
         4'h3: segs = SEG_3[7:1];
         4'h4: segs = SEG_4[7:1];
         4'h5: segs = SEG_5[7:1];
         4'h6: segs = SEG_6[7:1];
         4'h7: segs = SEG_7[7:1];
         4'h8: segs = SEG_8[7:1];
         4'h9: segs = SEG_9[7:1];
         4'hA: segs = SEG_A[7:1];
         4'hB: segs = SEG_B[7:1];
         4'hC: segs = SEG_C[7:1];
         4'hD: segs = SEG_D[7:1];
         4'hE: segs = SEG_E[7:1];
         4'hF: segs = SEG_F[7:1];
         default: segs = SEG_BLANK[7:1];
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/tub_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tub_scan_driver
// Brief    : Time-multiplexed driver for two 4-digit seven-segment buses with
//            a shared digit select. Frames are handed over with an
//            update/busy handshake and take effect only at frame boundaries.
//            Each scan slot starts with a guard interval (all selects off) to
//            avoid ghosting.
// Revision : 1.0  initial release
// ============================================================================
module tub_scan_driver
   import tub_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int GUARD        = 8,
   parameter int BLINK_FRAMES = 125
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] digit_data,
   input  logic [7:0]  dp_mask,
   input  logic [7:0]  blank_mask,
   input  logic [7:0]  blink_mask,
   input  logic        update,
   output logic        busy,
   output logic        frame_start,
   output logic [7:0]  tub_segments_1,
   output logic [7:0]  tub_segments_2,
   output logic [7:0]  tub_select
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] GUARD_END = DIV_W'(GUARD);
   localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

   frame_t             pending;
   frame_t             active;
   logic [DIV_W-1:0]   div_cnt;
   logic [1:0]         slot;
   logic [FRM_W-1:0]   frame_cnt;
   logic               blink_phase;
   logic               frame_end;
   logic               swap;
   logic [3:0]         slot_onehot;
   logic [1:0][7:0]    seg_next;

   // While disabled the scan is frozen, so pending frames are applied at once
   assign frame_end   = enable && (div_cnt == DIV_LAST) && (slot == 2'd3);
   assign swap        = busy && (frame_end || !enable);
   assign slot_onehot = 4'b0001 << slot;

   // Handshake: latest update wins; the transfer uses the pending value held
   // before any same-cycle update
   always_ff @(posedge clk) begin
      if (!reset) begin
         pending <= '0;
         active  <= '0;
         busy    <= 1'b0;
      end else begin
         if (swap) begin
            active <= pending;
         end
         if (update) begin
            pending <= '{digits: digit_data, dp: dp_mask,
                         blank: blank_mask, blink: blink_mask};
            busy    <= 1'b1;
         end else if (swap) begin
            busy    <= 1'b0;
         end
      end
   end

   // Scan counters and blink phase; held at zero while disabled
   always_ff @(posedge clk) begin
      if (!reset || !enable) begin
         div_cnt     <= '0;
         slot        <= 2'd0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            slot    <= slot + 2'd1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
         if (frame_end) begin
            if (frame_cnt == FRM_LAST) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt   <= frame_cnt + 1'b1;
            end
         end
      end
   end

   // Per-bus digit lookup: bus 0 shows digit slot, bus 1 shows digit slot+4
   for (genvar b = 0; b < 2; b++) begin : g_bus
      localparam logic BANK = (b != 0);
      logic [2:0] idx;
      logic [3:0] nib;
      logic [6:0] code;
      logic       dark;

      assign idx  = {BANK, slot};
      assign nib  = active.digits[{idx, 2'b00} +: 4];
      assign dark = active.blank[idx] | (active.blink[idx] & blink_phase);

      seg7_encoder u_enc (
         .nibble (nib),
         .segs   (code)
      );

      assign seg_next[b] = dark ? SEG_BLANK : {code, active.dp[idx]};
   end

   // Registered pin outputs, one cycle behind the scan counters
   always_ff @(posedge clk) begin
      if (!reset || !enable) begin
         frame_start    <= 1'b0;
         tub_select     <= '0;
         tub_segments_1 <= '0;
         tub_segments_2 <= '0;
      end else begin
         frame_start <= (div_cnt == '0) && (slot == 2'd0);
         if (div_cnt < GUARD_END) begin
            tub_select     <= '0;
            tub_segments_1 <= '0;
            tub_segments_2 <= '0;
         end else begin
            tub_select     <= {slot_onehot, slot_onehot};
            tub_segments_1 <= seg_next[0];
            tub_segments_2 <= seg_next[1];
         end
      end
   end

endmodule
`default_nettype wire
